// File: rtl/blink_rate_detector.sv
// ---------------------------------------------------------------------------
// blink_rate_detector
//
// Measures the half-period of a slow toggling input and classifies it as
// one of four nominal blink rates (10, 5, 2, 1 Hz). It is the receive-side
// counterpart of the blink generator.
//
// Ports:
//   i_Clk     system clock
//   i_Rst     synchronous, active-high reset
//   i_Signal  toggling input, asynchronous to i_Clk
//   o_Valid   one-cycle pulse when a new measurement completes
//   o_Period  last measured half-period in clocks
//   o_Rate    0 = unknown, 1 = 10 Hz, 2 = 5 Hz, 3 = 2 Hz, 4 = 1 Hz
//   o_Locked  two consecutive measurements gave the same nonzero code
//   o_Idle    armed and waiting for the first edge
// ---------------------------------------------------------------------------
module blink_rate_detector #(
    parameter int unsigned g_COUNT_10HZ = 1250000,
    parameter int unsigned g_COUNT_5HZ  = 2500000,
    parameter int unsigned g_COUNT_2HZ  = 6250000,
    parameter int unsigned g_COUNT_1HZ  = 12500000,
    parameter int unsigned g_TOL_SHIFT  = 3,
    parameter int unsigned g_CNT_W      = 25
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Signal,
    output logic               o_Valid,
    output logic [g_CNT_W-1:0] o_Period,
    output logic [2:0]         o_Rate,
    output logic               o_Locked,
    output logic               o_Idle
);

    localparam int unsigned RATE_W = 3;

    // Nominal half-periods and their match tolerances at counter width
    localparam logic [g_CNT_W-1:0] NOM_10  = g_CNT_W'(g_COUNT_10HZ);
    localparam logic [g_CNT_W-1:0] NOM_5   = g_CNT_W'(g_COUNT_5HZ);
    localparam logic [g_CNT_W-1:0] NOM_2   = g_CNT_W'(g_COUNT_2HZ);
    localparam logic [g_CNT_W-1:0] NOM_1   = g_CNT_W'(g_COUNT_1HZ);
    localparam logic [g_CNT_W-1:0] TOL_10  = g_CNT_W'(g_COUNT_10HZ >> g_TOL_SHIFT);
    localparam logic [g_CNT_W-1:0] TOL_5   = g_CNT_W'(g_COUNT_5HZ >> g_TOL_SHIFT);
    localparam logic [g_CNT_W-1:0] TOL_2   = g_CNT_W'(g_COUNT_2HZ >> g_TOL_SHIFT);
    localparam logic [g_CNT_W-1:0] TOL_1   = g_CNT_W'(g_COUNT_1HZ >> g_TOL_SHIFT);
    localparam logic [g_CNT_W-1:0] TIMEOUT = g_CNT_W'(2 * g_COUNT_1HZ);

    localparam logic [RATE_W-1:0] RATE_NONE = RATE_W'(0);
    localparam logic [RATE_W-1:0] RATE_10HZ = RATE_W'(1);
    localparam logic [RATE_W-1:0] RATE_5HZ  = RATE_W'(2);
    localparam logic [RATE_W-1:0] RATE_2HZ  = RATE_W'(3);
    localparam logic [RATE_W-1:0] RATE_1HZ  = RATE_W'(4);

    typedef enum logic [0:0] {
        S_WAIT    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    // Larger-minus-smaller distance; never wraps since m <= TIMEOUT
    function automatic logic in_window(input logic [g_CNT_W-1:0] m,
                                       input logic [g_CNT_W-1:0] nom,
                                       input logic [g_CNT_W-1:0] tol);
        logic [g_CNT_W-1:0] diff;
        diff = (m >= nom) ? (m - nom) : (nom - m);
        return (diff <= tol);
    endfunction

    // Fastest rate wins where windows overlap
    function automatic logic [RATE_W-1:0] classify(input logic [g_CNT_W-1:0] m);
        logic [RATE_W-1:0] code;
        code = RATE_NONE;
        if (in_window(m, NOM_10, TOL_10)) begin
            code = RATE_10HZ;
        end else if (in_window(m, NOM_5, TOL_5)) begin
            code = RATE_5HZ;
        end else if (in_window(m, NOM_2, TOL_2)) begin
            code = RATE_2HZ;
        end else if (in_window(m, NOM_1, TOL_1)) begin
            code = RATE_1HZ;
        end
        return code;
    endfunction

    logic                s1_q,     s1_d;
    logic                s2_q,     s2_d;
    logic                prev_q,   prev_d;
    state_t              state_q,  state_d;
    logic [g_CNT_W-1:0]  cnt_q,    cnt_d;
    logic                valid_q,  valid_d;
    logic [g_CNT_W-1:0]  period_q, period_d;
    logic [RATE_W-1:0]   rate_q,   rate_d;
    logic                locked_q, locked_d;
    logic                idle_q,   idle_d;

    logic                edge_c;
    logic [RATE_W-1:0]   code_c;

    // Next-state and output logic
    always_comb begin
        s1_d     = i_Signal;
        s2_d     = s1_q;
        prev_d   = s2_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        period_d = period_q;
        rate_d   = rate_q;
        locked_d = locked_q;
        idle_d   = idle_q;

        edge_c   = s2_q ^ prev_q;
        code_c   = classify(cnt_q);

        case (state_q)
            S_WAIT: begin
                // First edge only arms the measurement
                if (edge_c) begin
                    cnt_d   = g_CNT_W'(1);
                    state_d = S_MEASURE;
                    idle_d  = 1'b0;
                end
            end
            S_MEASURE: begin
                // An edge takes priority over a coincident timeout
                if (edge_c) begin
                    valid_d  = 1'b1;
                    period_d = cnt_q;
                    rate_d   = code_c;
                    locked_d = (code_c != RATE_NONE) && (code_c == rate_q);
                    cnt_d    = g_CNT_W'(1);
                end else if (cnt_q == TIMEOUT) begin
                    state_d  = S_WAIT;
                    cnt_d    = '0;
                    rate_d   = RATE_NONE;
                    locked_d = 1'b0;
                    idle_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q + g_CNT_W'(1);
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            rate_q   <= RATE_NONE;
            locked_q <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            rate_q   <= rate_d;
            locked_q <= locked_d;
            idle_q   <= idle_d;
        end
    end

    assign o_Valid  = valid_q;
    assign o_Period = period_q;
    assign o_Rate   = rate_q;
    assign o_Locked = locked_q;
    assign o_Idle   = idle_q;

endmodule

// File: doc/blink_rate_detector.md
# blink_rate_detector

Measures the half-period of a slow toggling input, such as an LED drive from the blink generator or an external pin, and classifies it as one of four nominal blink rates: 10, 5, 2 or 1 Hz. It sits on the receive side of the blink path and is the inverse of the blink generator. Per-measurement results drive self-check logic and status LEDs, and a lock flag reports a stable rate.

## Interface
- g_COUNT_10HZ, 1250000, nominal half-period in clocks for 10 Hz (25 MHz clock)
- g_COUNT_5HZ, 2500000, nominal half-period for 5 Hz
- g_COUNT_2HZ, 6250000, nominal half-period for 2 Hz
- g_COUNT_1HZ, 12500000, nominal half-period for 1 Hz
- g_TOL_SHIFT, 3, match tolerance for each class is g_COUNT_x >> g_TOL_SHIFT
- g_CNT_W, 25, counter and period width; must hold 2*g_COUNT_1HZ
- i_Clk  in  1  system clock
- i_Rst  in  1  reset; one clock; reset is synchronous and active-high
- i_Signal  in  1  toggling input, asynchronous to i_Clk
- o_Valid  out  1  one-cycle pulse when a new measurement completes
- o_Period  out  g_CNT_W  last measured half-period in clocks
- o_Rate  out  3  rate code: 0 = unknown, 1 = 10 Hz, 2 = 5 Hz, 3 = 2 Hz, 4 = 1 Hz
- o_Locked  out  1  two consecutive measurements gave the same nonzero code
- o_Idle  out  1  no edge is being tracked (armed, waiting for the first edge)

## Operation
- Input path:
  - i_Signal passes through a 2-flop synchronizer (s1, s2), then a history flop (prev).
  - An edge (either polarity) is detected in any cycle where s2 != prev.
- States: S_WAIT (reset state) and S_MEASURE.
- S_WAIT, on edge:
  - Load counter with 1 and go to S_MEASURE.
  - o_Idle goes 0. No o_Valid pulse is issued.
- S_MEASURE, each cycle without an edge:
  - Counter increments by 1.
  - When counter == 2*g_COUNT_1HZ (timeout), go to S_WAIT.
  - On timeout: o_Rate <= 0, o_Locked <= 0, o_Idle <= 1. o_Period is held.
- S_MEASURE, on edge:
  - Measured value M = counter, i.e. clocks between the two detected edges.
  - o_Period <= M and o_Valid pulses.
  - Counter reloads to 1; stay in S_MEASURE.
- Classification of M:
  - Class x matches when |M - g_COUNT_x| <= g_COUNT_x >> g_TOL_SHIFT.
  - If windows overlap, the fastest rate wins (code 1 has highest priority).
  - No match gives code 0.
- Lock:
  - On each measurement, o_Locked <= (new code != 0) && (new code == previous o_Rate).
  - o_Rate <= new code in the same cycle.
- Edge and timeout in the same cycle: the edge wins. The measurement is performed normally and classifies as 0 when out of range.
- Arithmetic: the difference is computed unsigned as a larger-minus-smaller subtraction; no wrap is possible because the counter never exceeds the timeout value.

## Timing
- Reset values: s1, s2 and prev = 0; state S_WAIT; counter 0; o_Valid 0; o_Period 0; o_Rate 0; o_Locked 0; o_Idle 1.
- If i_Signal is high at reset release, the resulting edge only arms S_WAIT and never produces o_Valid.
- Latency: a new i_Signal level first sampled at edge k is detected at edge k+2. o_Valid, o_Period, o_Rate and o_Locked are registered, and all update together at edge k+2.
- o_Valid is high for exactly 1 cycle per measurement.
- o_Period, o_Rate and o_Locked hold their values between measurements.
- Reset mid-measurement: all state and outputs return to reset values at the next clock edge. No o_Valid is issued for the partial period.
- Minimum measurable M is 1, which occurs with toggles on consecutive cycles after synchronization.

## Test plan
All scenarios use g_COUNT_10HZ=5, g_COUNT_5HZ=10, g_COUNT_2HZ=25, g_COUNT_1HZ=50, g_TOL_SHIFT=2 and g_CNT_W=8. This gives tolerances of 1, 2, 6 and 12, and a timeout of 100.
- Toggle i_Signal every 10 clocks:
  - First edge: o_Idle falls and there is no o_Valid.
  - Each later edge: o_Valid with o_Period=10 and o_Rate=2.
  - o_Locked = 0 after the 1st measurement and 1 from the 2nd onward.
- Window boundaries, half-periods 6, 7, 19, 18, 31, 32 give o_Rate 1, 0, 3, 0, 3, 0. o_Locked falls on each code-0 result.
- Rate switch from 5-clock to 25-clock toggles:
  - First 25-clock measurement: o_Rate=3, o_Locked=0.
  - Next measurement: o_Locked=1.
- Stop toggling while locked at 50:
  - 100 clocks after the last edge: o_Idle=1, o_Rate=0, o_Locked=0, no o_Valid, o_Period still 50.
  - The next edge only re-arms.
- Edge and timeout coincide: arrange an edge exactly 100 clocks after the last one. Required response: o_Valid with o_Period=100 and o_Rate=0, and the state stays S_MEASURE.
- Reset mid-measurement:
  - Assert i_Rst for 1 cycle 20 clocks into a 50-clock half-period with i_Signal held high. Next cycle, all outputs are at reset values.
  - The first post-reset edge gives no o_Valid.
  - A measurement is produced only after the second post-reset edge.
